// File: rtl/regwb_pkg.sv
// regwb_pkg: shared widths, requester identifiers and helpers for the
// register-file writeback arbiter (regwb_arbiter, regwb_slot).
package regwb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;

   // Identifies a requester; also used for the priority pointer and age flag.
   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_e;

   // Contents of one holding slot.
   typedef struct packed {
      logic                  vld;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } slot_t;

   // One-hot decode of a register address into a NUM_REGS-wide mask.
   function automatic logic [NUM_REGS-1:0] reg_decode(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] onehot;
      onehot       = '0;
      onehot[addr] = 1'b1;
      return onehot;
   endfunction

   // Writes to register 0 are architecturally void and never buffered.
   function automatic logic is_void_addr(input logic [REG_ADDR_W-1:0] addr);
      return (addr == '0);
   endfunction

endpackage

// File: rtl/regwb_slot.sv
// regwb_slot: single-entry holding buffer for one writeback requester.
// Accepts a write when empty or when its current content is being issued
// this cycle, so a requester can sustain one write per cycle. Writes to
// register 0 are accepted but dropped.
module regwb_slot
   import regwb_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [REG_ADDR_W-1:0] req_addr,
   input  logic [REG_DATA_W-1:0] req_data,
   input  logic                  issue,
   output logic                  ready,
   output logic                  load,
   output logic                  slot_vld,
   output logic [REG_ADDR_W-1:0] slot_addr,
   output logic [REG_DATA_W-1:0] slot_data
);

   slot_t slot_p0;

   // Handshake: ready when empty or draining this edge; reset blocks acceptance.
   always_comb begin
      ready = !rst && (!slot_p0.vld || issue);
      load  = req_valid && ready && !is_void_addr(req_addr);
   end

   // Slot occupancy: reload wins over the clear caused by issuing.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_p0.vld <= 1'b0;
      end else if (load) begin
         slot_p0.vld <= 1'b1;
      end else if (issue) begin
         slot_p0.vld <= 1'b0;
      end
   end

   // Slot payload: only meaningful while vld is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         slot_p0.addr <= req_addr;
         slot_p0.data <= req_data;
      end
   end

   assign slot_vld  = slot_p0.vld;
   assign slot_addr = slot_p0.addr;
   assign slot_data = slot_p0.data;

endmodule

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: merges ALU (A) and load (B) writebacks onto the single
// register-file write port. Each requester owns one holding slot; one slot
// is issued per cycle through a registered write stage.
// Contention policy: two valid slots to the same register always issue
// oldest first. Otherwise, with REGWB_RR_EN defined, a round-robin pointer
// picks the winner and moves to the loser after every contended grant;
// without REGWB_RR_EN, A always wins.
module regwb_arbiter
   import regwb_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  A_Valid,
   output logic                  A_Ready,
   input  logic [REG_ADDR_W-1:0] A_Addr,
   input  logic [REG_DATA_W-1:0] A_Data,
   input  logic                  B_Valid,
   output logic                  B_Ready,
   input  logic [REG_ADDR_W-1:0] B_Addr,
   input  logic [REG_DATA_W-1:0] B_Data,
   output logic [REG_ADDR_W-1:0] WriteRegister,
   output logic [REG_DATA_W-1:0] WriteData,
   output logic                  RegWrite,
   output logic [NUM_REGS-1:0]   Pending
);

   logic                  a_vld_p0;
   logic [REG_ADDR_W-1:0] a_addr_p0;
   logic [REG_DATA_W-1:0] a_data_p0;
   logic                  a_load;
   logic                  b_vld_p0;
   logic [REG_ADDR_W-1:0] b_addr_p0;
   logic [REG_DATA_W-1:0] b_data_p0;
   logic                  b_load;

   logic                  contended;
   logic                  a_wins;
   logic                  grant_a;
   logic                  grant_b;

   req_e                  age_p0;
`ifdef REGWB_RR_EN
   req_e                  ptr_p0;
`endif

   logic                  vld_p1;
   logic [REG_ADDR_W-1:0] wr_addr_p1;
   logic [REG_DATA_W-1:0] wr_data_p1;

   // ---- stage p0: holding slots ----
   regwb_slot u_slot_a (
      .clk       (Clk),
      .rst       (Reset),
      .req_valid (A_Valid),
      .req_addr  (A_Addr),
      .req_data  (A_Data),
      .issue     (grant_a),
      .ready     (A_Ready),
      .load      (a_load),
      .slot_vld  (a_vld_p0),
      .slot_addr (a_addr_p0),
      .slot_data (a_data_p0)
   );

   regwb_slot u_slot_b (
      .clk       (Clk),
      .rst       (Reset),
      .req_valid (B_Valid),
      .req_addr  (B_Addr),
      .req_data  (B_Data),
      .issue     (grant_b),
      .ready     (B_Ready),
      .load      (b_load),
      .slot_vld  (b_vld_p0),
      .slot_addr (b_addr_p0),
      .slot_data (b_data_p0)
   );

   // Grant from slot state only; same-register conflicts keep program order.
   always_comb begin
      contended = a_vld_p0 && b_vld_p0;
      a_wins    = 1'b1;
      if (contended) begin
         if (a_addr_p0 == b_addr_p0) begin
            a_wins = (age_p0 == REQ_A);
         end else begin
`ifdef REGWB_RR_EN
            a_wins = (ptr_p0 == REQ_A);
`else
            a_wins = 1'b1;
`endif
         end
      end
      grant_a = a_vld_p0 && (!b_vld_p0 || a_wins);
      grant_b = b_vld_p0 && !grant_a;
   end

   // Age flag: names the slot whose surviving content was loaded first.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         age_p0 <= REQ_A;
      end else if (a_load && b_load) begin
         age_p0 <= REQ_A;
      end else if (a_load && b_vld_p0 && !grant_b) begin
         age_p0 <= REQ_B;
      end else if (b_load && a_vld_p0 && !grant_a) begin
         age_p0 <= REQ_A;
      end
   end

`ifdef REGWB_RR_EN
   // Round-robin pointer: hands priority to the loser of each contended grant.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ptr_p0 <= REQ_A;
      end else if (contended) begin
         ptr_p0 <= grant_a ? REQ_B : REQ_A;
      end
   end
`endif

   // Pending scoreboard: registers with a buffered write; r0 never appears.
   always_comb begin
      Pending = '0;
      if (a_vld_p0) begin
         Pending = Pending | reg_decode(a_addr_p0);
      end
      if (b_vld_p0) begin
         Pending = Pending | reg_decode(b_addr_p0);
      end
      Pending[0] = 1'b0;
   end

   // ---- stage p1: registered register-file write port ----
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vld_p1     <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         vld_p1 <= grant_a || grant_b;
         if (grant_a) begin
            wr_addr_p1 <= a_addr_p0;
            wr_data_p1 <= a_data_p0;
         end else if (grant_b) begin
            wr_addr_p1 <= b_addr_p0;
            wr_data_p1 <= b_data_p0;
         end
      end
   end

   assign RegWrite      = vld_p1;
   assign WriteRegister = wr_addr_p1;
   assign WriteData     = wr_data_p1;

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: scoreboard bench for regwb_arbiter. A queue-based
// reference model (slots tagged with load sequence numbers) predicts each
// cycle's write-port contents; a monitor pops and compares every cycle.
// Builds with or without REGWB_RR_EN to match the RTL.
module tb_regwb_arbiter;
   import regwb_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        A_Valid = 1'b0;
   logic        A_Ready;
   logic [4:0]  A_Addr = '0;
   logic [31:0] A_Data = '0;
   logic        B_Valid = 1'b0;
   logic        B_Ready;
   logic [4:0]  B_Addr = '0;
   logic [31:0] B_Data = '0;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [31:0] Pending;

   always #5 Clk = ~Clk;

   regwb_arbiter dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .A_Valid       (A_Valid),
      .A_Ready       (A_Ready),
      .A_Addr        (A_Addr),
      .A_Data        (A_Data),
      .B_Valid       (B_Valid),
      .B_Ready       (B_Ready),
      .B_Addr        (B_Addr),
      .B_Data        (B_Data),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .Pending       (Pending)
   );

   typedef struct {
      bit        we;
      bit [4:0]  addr;
      bit [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   errors  = 0;

   // Reference model state: index 0 = A, 1 = B.
   bit          m_vld[2];
   bit [4:0]    m_addr[2];
   bit [31:0]   m_data[2];
   int unsigned m_seq[2];
   int unsigned seq_ctr = 0;
   int          m_ptr = 0;
   bit [4:0]    m_last_addr = '0;
   bit [31:0]   m_last_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Which requester the model lets write this cycle (-1: none).
   function automatic int m_winner();
      if (m_vld[0] && m_vld[1]) begin
         if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef REGWB_RR_EN
         return m_ptr;
`else
         return 0;
`endif
      end
      if (m_vld[0]) return 0;
      if (m_vld[1]) return 1;
      return -1;
   endfunction

   // One clock of stimulus plus model update; expectation queued for the monitor.
   task automatic cycle(input bit rst, input bit av, input bit [4:0] aa, input bit [31:0] ad,
                        input bit bv, input bit [4:0] ba, input bit [31:0] bd);
      int        w;
      bit        rdy[2];
      bit        both;
      bit [31:0] pend;
      exp_t      e;
      @(negedge Clk);
      Reset = rst; A_Valid = av; A_Addr = aa; A_Data = ad;
      B_Valid = bv; B_Addr = ba; B_Data = bd;
      #1;
      w       = m_winner();
      both    = m_vld[0] && m_vld[1];
      rdy[0]  = !rst && (!m_vld[0] || w == 0);
      rdy[1]  = !rst && (!m_vld[1] || w == 1);
      check("a_ready", 32'(A_Ready), 32'(rdy[0]));
      check("b_ready", 32'(B_Ready), 32'(rdy[1]));
      pend = '0;
      for (int i = 0; i < 2; i++) if (m_vld[i]) pend[m_addr[i]] = 1'b1;
      check("pending", Pending, pend);
      if (rst) begin
         m_vld[0] = 0; m_vld[1] = 0; m_ptr = 0;
         m_last_addr = '0; m_last_data = '0;
         e = '{we: 1'b0, addr: 5'd0, data: 32'd0};
      end else begin
         if (w >= 0) begin
            m_last_addr = m_addr[w];
            m_last_data = m_data[w];
            m_vld[w] = 0;
            if (both) m_ptr = 1 - w;
            e = '{we: 1'b1, addr: m_last_addr, data: m_last_data};
         end else begin
            e = '{we: 1'b0, addr: m_last_addr, data: m_last_data};
         end
         if (av && rdy[0] && aa != 0) begin
            m_vld[0] = 1; m_addr[0] = aa; m_data[0] = ad; m_seq[0] = seq_ctr; seq_ctr++;
         end
         if (bv && rdy[1] && ba != 0) begin
            m_vld[1] = 1; m_addr[1] = ba; m_data[1] = bd; m_seq[1] = seq_ctr; seq_ctr++;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compares the write port with the expectation for this cycle.
   exp_t me;
   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         check("regwrite", 32'(RegWrite), 32'(me.we));
         check("write_register", 32'(WriteRegister), 32'(me.addr));
         check("write_data", WriteData, me.data);
      end
   end

   initial begin
      bit av, bv;
      // Reset
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      // Single write r2=42
      cycle(0, 1, 5'd2, 32'd42, 0, 0, 0);
      idle(3);
      // Write to r0 is dropped
      cycle(0, 1, 5'd0, 32'd15, 0, 0, 0);
      idle(3);
      // Contended pair, twice
      cycle(0, 1, 5'd3, 32'd19, 1, 5'd4, 32'd20);
      idle(3);
      cycle(0, 1, 5'd3, 32'd19, 1, 5'd4, 32'd20);
      idle(3);
      // Move pointer to B, then same-register pair loaded together
      cycle(0, 1, 5'd6, 32'd60, 1, 5'd7, 32'd70);
      idle(3);
      cycle(0, 1, 5'd5, 32'd1, 1, 5'd5, 32'd2);
      idle(3);
      // Same register, B loaded before A
      cycle(0, 0, 0, 0, 1, 5'd9, 32'd90);
      cycle(0, 1, 5'd9, 32'd91, 1, 5'd9, 32'd92);
      cycle(0, 1, 5'd9, 32'd93, 0, 0, 0);
      idle(4);
      // A streams r1..r10
      for (int i = 1; i <= 10; i++) cycle(0, 1, 5'(i), $urandom, 0, 0, 0);
      idle(3);
      // Both slots full, then reset drops them
      cycle(0, 1, 5'd11, 32'd111, 1, 5'd12, 32'd122);
      cycle(1, 0, 0, 0, 0, 0, 0);
      idle(3);
      // Random traffic with collisions, r0 writes and occasional resets
      for (int i = 0; i < 600; i++) begin
         av = ($urandom_range(0, 3) != 0);
         bv = ($urandom_range(0, 2) != 0);
         cycle(($urandom_range(0, 63) == 0), av, 5'($urandom_range(0, 7)), $urandom,
               bv, 5'($urandom_range(0, 7)), $urandom);
      end
      idle(4);
      repeat (2) @(negedge Clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
